tremolo: RTL and testbench

- Tremolo audio effect: amplitude-modulates a 32-bit signed sample stream with a triangle LFO gain.
- Sits in the pedal effects chain, one sample per clock at the 48 kHz sample clock.
- All LFO rate timing is derived internally from the sample clock by a prescaler; there are no auxiliary rate clocks.
- en[1] selects effect or bypass; options selects one of four LFO rates.

---
 rtl/tremolo.sv | 92 +++++++++
 tb/tb_tremolo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tremolo.sv
// Tremolo effect: scales each 32-bit sample by a 9-bit triangle-LFO gain (256 = unity).
// LFO rate comes from a sample-clock prescaler plus a 3-bit sub-divider masked by options.
module tremolo #(
    parameter int DIV_BASE = 126,
    parameter int STEP     = 8
) (
    input  logic        clk_48,
    input  logic        rst_n,
    input  logic [31:0] x,
    output logic [31:0] y,
    input  logic [3:0]  options,
    input  logic [3:0]  en
);

    localparam int         PW     = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
    localparam logic [8:0] G_MAX  = 9'd256;
    localparam logic [8:0] G_STEP = 9'(STEP);

    logic [PW-1:0]      presc_q, presc_d;
    logic [2:0]         sub_q, sub_d;
    logic [8:0]         g_q, g_d;
    logic               up_q, up_d;
    logic [31:0]        y_q, y_d;
    logic               tick, rate_on, lfo_step;
    logic [2:0]         mask;
    logic signed [41:0] prod;
    logic               unused_bits;

    // Lowest set option bit wins; no bit set freezes the LFO.
    always_comb begin
        mask    = 3'd0;
        rate_on = |options;
        if (options[0])      mask = 3'd0;
        else if (options[1]) mask = 3'd1;
        else if (options[2]) mask = 3'd3;
        else if (options[3]) mask = 3'd7;
    end

    always_comb begin
        tick     = (presc_q == PW'(DIV_BASE - 1));
        presc_d  = tick ? '0 : presc_q + PW'(1);
        sub_d    = tick ? sub_q + 3'd1 : sub_q;
        lfo_step = tick && rate_on && ((sub_q & mask) == 3'd0);
        g_d      = g_q;
        up_d     = up_q;
        if (lfo_step) begin
            if (up_q) begin
                if (g_q >= G_MAX - G_STEP) begin
                    g_d  = G_MAX;
                    up_d = 1'b0;
                end else begin
                    g_d = g_q + G_STEP;
                end
            end else begin
                if (g_q <= G_STEP) begin
                    g_d  = 9'd0;
                    up_d = 1'b1;
                end else begin
                    g_d = g_q - G_STEP;
                end
            end
        end
        // Product uses the pre-update gain; >>>8 floors via arithmetic shift.
        prod = $signed(x) * $signed({1'b0, g_q});
        y_d  = en[1] ? prod[39:8] : x;
        if (!en[1]) begin
            g_d   = G_MAX;
            up_d  = 1'b0;
            sub_d = 3'd0;
        end
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sub_q   <= 3'd0;
            g_q     <= G_MAX;
            up_q    <= 1'b0;
            y_q     <= 32'd0;
        end else begin
            presc_q <= presc_d;
            sub_q   <= sub_d;
            g_q     <= g_d;
            up_q    <= up_d;
            y_q     <= y_d;
        end
    end

    assign y           = y_q;
    assign unused_bits = ^{prod[41:40], prod[7:0], en[3:2], en[0]};

endmodule

// File: tb/tb_tremolo.sv
// Directed bench for tremolo: driver queues hand-computed y values per clock edge,
// a monitor pops and compares one entry after every rising edge.
module tb_tremolo;

    logic        clk;
    logic        rst_n;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  options;
    logic [3:0]  en;

    typedef struct {
        int          e;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   edges;

    tremolo dut (
        .clk_48 (clk),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y),
        .options(options),
        .en     (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release; edge 1 is the first one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(posedge clk) begin
        exp_t it;
        #1;
        if (q.size() > 0) begin
            it = q.pop_front();
            checks++;
            if (y !== it.exp) begin
                errors++;
                $display("FAIL y edge %0d got %0d want %0d", it.e, $signed(y), $signed(it.exp));
            end
        end
    end

    // Park on the negedge just before rising edge e.
    task automatic at(input int e);
        while (edges < e - 1) @(negedge clk);
    endtask

    task automatic drv(input int e, input logic [31:0] xin, input logic [31:0] exp);
        exp_t it;
        at(e);
        x      = xin;
        it.e   = e;
        it.exp = exp;
        q.push_back(it);
    endtask

    task automatic push0();
        exp_t it;
        it.e   = 0;
        it.exp = 32'd0;
        q.push_back(it);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        x       = 32'd1000;
        en      = 4'b0010;
        options = 4'b0001;
        @(negedge clk); push0();
        @(negedge clk); push0();
        @(negedge clk); rst_n = 1'b1;

        // First LFO step at edge 126, then negative rounding.
        drv(1,   32'd1000, 32'd1000);
        drv(126, 32'd1000, 32'd1000);
        drv(127, 32'd1000, 32'd968);
        drv(128, -32'sd1000, -32'sd969);
        drv(2017, -32'sd1, -32'sd1);
        drv(2018, 32'd1, 32'd0);
        drv(2019, 32'd25600, 32'd12800);

        // Triangle down to zero, extremes at g=0, back up to unity.
        drv(4032, 32'd25600, 32'd800);
        drv(4033, 32'd25600, 32'd0);
        drv(4034, 32'h7FFF_FFFF, 32'd0);
        drv(4035, 32'h8000_0000, 32'd0);
        drv(4036, 32'd25600, 32'd0);
        drv(4159, 32'd25600, 32'd800);
        drv(8064, 32'd25600, 32'd24800);
        drv(8065, 32'd25600, 32'd25600);
        drv(8066, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        drv(8067, 32'h8000_0000, 32'h8000_0000);
        drv(8191, 32'd25600, 32'd24800);

        // Slowest rate: steps at ticks 73 and 81 only.
        at(8192); options = 4'b1000;
        drv(8317,  32'd25600, 32'd24800);
        drv(9198,  32'd25600, 32'd24800);
        drv(9199,  32'd25600, 32'd24000);
        drv(10207, 32'd25600, 32'd23200);

        at(10208); options = 4'b0100;
        drv(10710, 32'd25600, 32'd23200);
        drv(10711, 32'd25600, 32'd22400);
        drv(10837, 32'd25600, 32'd22400);
        drv(11215, 32'd25600, 32'd21600);

        at(11216); options = 4'b0000;
        drv(13400, 32'd25600, 32'd21600);

        at(13401); options = 4'b0110;
        drv(13482, 32'd25600, 32'd21600);
        drv(13483, 32'd25600, 32'd20800);
        drv(13609, 32'd25600, 32'd20800);
        drv(13735, 32'd25600, 32'd20000);

        // Bypass, then re-enable at the slowest rate: sub-divider must restart at 0.
        at(13736); en = 4'b0000;
        drv(13736, -32'sd5, -32'sd5);
        drv(13737, 32'd7, 32'd7);
        at(13741); en = 4'b0010; options = 4'b1000;
        drv(13741, 32'd25600, 32'd25600);
        drv(13860, 32'd25600, 32'd25600);
        drv(13861, 32'd25600, 32'd24800);

        // Fastest rate down to 0 and up to 120, then reset mid-run.
        at(13862); options = 4'b0001;
        drv(17767, 32'd25600, 32'd0);
        drv(19657, 32'd25600, 32'd12000);
        at(19700);
        rst_n = 1'b0;
        #2;
        checks++;
        if (y !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_y got %0d want 0", $signed(y));
        end
        @(negedge clk); push0();
        @(negedge clk); rst_n = 1'b1;
        drv(1,   32'd25600, 32'd25600);
        drv(126, 32'd25600, 32'd25600);
        drv(127, 32'd25600, 32'd24800);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
